fmap_stream_reader: RTL and testbench

//  Reader side of the conv output feature-map RAM. Once the conv engine has written its
//  25x20x8 int8 map and a run is started, this block reads the map linearly from the RAM.
//  It streams the bytes to the next layer (FC/host DMA) on a valid/ready byte stream.

---
 rtl/yoda_pkg.sv | 10 +
 rtl/sync_fifo.sv | 67 ++++++
 rtl/fmap_stream_reader.sv | 123 ++++++++++++
 tb/tb_fmap_stream_reader.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/yoda_pkg.sv
// Constants and FSM encoding shared between the conv engine and its output-map reader.
package yoda_pkg;
    localparam int FMAP_H      = 25;
    localparam int FMAP_W      = 20;
    localparam int FMAP_C      = 8;
    localparam int FMAP_WORDS  = FMAP_H * FMAP_W * FMAP_C;
    localparam int FMAP_ADDR_W = 13;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} fsm_state_e;
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count and a flush that empties it in one cycle.
module sync_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 9,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (do_pop) rd_ptr_d = next_ptr(rd_ptr_q);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/fmap_stream_reader.sv
// Streams the conv output feature map out of its RAM, in address order, on a valid/ready
// byte stream. Reads are credit-limited so returning RAM data always has a FIFO slot.
module fmap_stream_reader
    import yoda_pkg::*;
#(
    parameter int ADDR_W     = FMAP_ADDR_W,
    parameter int DATA_W     = 8,
    parameter int NUM_WORDS  = FMAP_WORDS,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic signed [DATA_W-1:0] rd_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_data,
    output logic                     m_last
);
    localparam int CNT_W = $clog2(NUM_WORDS);
    localparam int CRD_W = $clog2(FIFO_DEPTH + 1);

    fsm_state_e        state_q, state_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CRD_W-1:0]  inflight_q, inflight_d;
    logic [RD_LAT-1:0] tag_vld_q, tag_vld_d, tag_last_q, tag_last_d;

    logic              fifo_push, fifo_pop, fifo_flush, fifo_empty;
    logic [DATA_W:0]   fifo_din, fifo_dout;
    logic [CRD_W-1:0]  fifo_count;
    logic              issue_last, credit_ok;

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W + 1)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (fifo_flush),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign m_valid    = !fifo_empty;
    assign fifo_pop   = m_valid && m_ready;
    assign m_data     = fifo_dout[DATA_W-1:0];
    assign m_last     = m_valid && fifo_dout[DATA_W];
    assign fifo_push  = tag_vld_q[RD_LAT-1];
    assign fifo_din   = {tag_last_q[RD_LAT-1], rd_data};
    assign busy       = (state_q == READ) || (state_q == DRAIN);
    assign done       = (state_q == FIN);
    assign fifo_flush = abort && busy;
    assign rd_addr    = ADDR_W'(issue_cnt_q);
    assign issue_last = (issue_cnt_q == CNT_W'(NUM_WORDS - 1));

    // The slot freed by a pop this cycle is reusable now: that read's data lands
    // RD_LAT cycles later, after the pop has left. This is what keeps 1 element/cycle.
    assign credit_ok = (int'(fifo_count) + int'(inflight_q) - int'(fifo_pop)) < FIFO_DEPTH;
    assign rd_en     = (state_q == READ) && credit_ok && !abort;

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        inflight_d  = inflight_q + CRD_W'(rd_en) - CRD_W'(tag_vld_q[RD_LAT-1]);
        tag_vld_d   = tag_vld_q;
        tag_last_d  = tag_last_q;
        tag_vld_d[0]  = rd_en;
        tag_last_d[0] = rd_en && issue_last;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_last_d[i] = tag_last_q[i-1];
        end

        unique case (state_q)
            IDLE: if (start && !abort) begin
                state_d     = READ;
                issue_cnt_d = '0;
            end
            READ: if (rd_en) begin
                if (issue_last) state_d = DRAIN;
                else            issue_cnt_d = issue_cnt_q + 1'b1;
            end
            DRAIN: if (fifo_pop && m_last) state_d = FIN;
            FIN: begin
                state_d     = IDLE;
                issue_cnt_d = '0;
            end
            default: state_d = IDLE;
        endcase

        // Cancel drops every read still in the RAM pipe along with the buffered data.
        if (fifo_flush) begin
            state_d     = IDLE;
            issue_cnt_d = '0;
            inflight_d  = '0;
            tag_vld_d   = '0;
            tag_last_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            inflight_q  <= '0;
            tag_vld_q   <= '0;
            tag_last_q  <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            inflight_q  <= inflight_d;
            tag_vld_q   <= tag_vld_d;
            tag_last_q  <= tag_last_d;
        end
    end
endmodule

// File: tb/tb_fmap_stream_reader.sv
// Drives two readers (1-cycle RAM/2-deep FIFO and 2-cycle RAM/3-deep FIFO) with the same
// control stimulus and checks each against a transfer-count model of the stream.
module tb_fmap_stream_reader;
    import yoda_pkg::*;
    localparam int N = FMAP_WORDS;

    logic        clk = 1'b0;
    logic        rst, start, abort, m_ready;
    logic        busy [2], done [2], rd_en [2], m_valid [2], m_last [2];
    logic [12:0] rd_addr [2];
    logic [7:0]  m_data [2];
    logic [7:0]  rd_data_a, rd_data_b, rd_pipe_b;
    int          cyc = 0;

    int   n_vec = 0, n_err = 0;
    int   issued [2], xfer [2], start_cyc [2];
    bit   busy_e [2], done_e [2], stall_prev [2];
    logic [7:0] data_prev [2];
    bit   full_rate;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mem_val(input int i);
        logic [7:0] b;
        b = i[7:0];
        return b - 8'd128;
    endfunction
    function automatic int lat(input int d); return (d == 0) ? 1 : 2; endfunction
    function automatic int dep(input int d); return (d == 0) ? 2 : 3; endfunction

    always @(posedge clk) if (rd_en[0]) rd_data_a <= mem_val(int'(rd_addr[0]));
    always @(posedge clk) begin
        if (rd_en[1]) rd_pipe_b <= mem_val(int'(rd_addr[1]));
        rd_data_b <= rd_pipe_b;
    end

    fmap_stream_reader #(.RD_LAT(1), .FIFO_DEPTH(2)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy[0]), .done(done[0]),
        .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data_a), .m_valid(m_valid[0]),
        .m_ready(m_ready), .m_data(m_data[0]), .m_last(m_last[0]));

    fmap_stream_reader #(.RD_LAT(2), .FIFO_DEPTH(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy[1]), .done(done[1]),
        .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data_b), .m_valid(m_valid[1]),
        .m_ready(m_ready), .m_data(m_data[1]), .m_last(m_last[1]));

    task automatic chk(input string tag, input int d, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s dut%0d: got %0h expected %0h", tag, d, got, want);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            issued[d] = 0; xfer[d] = 0; busy_e[d] = 0; done_e[d] = 0; stall_prev[d] = 0;
        end
    endtask

    task automatic chk_zero();
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", d, busy[d], 0);     chk("rst_done", d, done[d], 0);
            chk("rst_rd_en", d, rd_en[d], 0);   chk("rst_valid", d, m_valid[d], 0);
            chk("rst_last", d, m_last[d], 0);   chk("rst_addr", d, rd_addr[d], 0);
            chk("rst_data", d, m_data[d], 0);
        end
    endtask

    // One clock cycle: drive inputs, check both DUTs against the model, advance the model.
    task automatic tick(input bit st, input bit ab, input int rmode);
        @(negedge clk);
        start = st;
        abort = ab;
        if (rmode == 2) m_ready = 1'($urandom_range(0, 1));
        else            m_ready = (rmode == 1);
        #1;
        for (int d = 0; d < 2; d++) begin
            bit hs, last_hs, abort_eff, start_eff;
            chk("busy", d, busy[d], busy_e[d]);
            chk("done", d, done[d], done_e[d]);
            if (done_e[d] && full_rate) chk("run_len", d, cyc - start_cyc[d], N + lat(d) + 2);
            if (!busy_e[d]) begin
                chk("idle_valid", d, m_valid[d], 0);
                chk("idle_rd_en", d, rd_en[d], 0);
            end
            if (rd_en[d]) begin
                chk("rd_addr", d, rd_addr[d], issued[d]);
                issued[d]++;
            end
            if (m_valid[d]) begin
                chk("m_data", d, m_data[d], mem_val(xfer[d]));
                chk("m_last", d, m_last[d], xfer[d] == N - 1);
                if (stall_prev[d]) chk("stable", d, m_data[d], data_prev[d]);
            end
            hs      = m_valid[d] && m_ready;
            last_hs = hs && (xfer[d] == N - 1);
            if (hs) xfer[d]++;
            chk("credit", d, (issued[d] - xfer[d]) <= dep(d), 1);
            stall_prev[d] = m_valid[d] && !m_ready;
            data_prev[d]  = m_data[d];
            abort_eff = ab && busy_e[d];
            start_eff = st && !ab && !busy_e[d] && !done_e[d];
            done_e[d] = last_hs && !ab;
            if (start_eff) begin
                busy_e[d] = 1; issued[d] = 0; xfer[d] = 0; start_cyc[d] = cyc;
            end else if (abort_eff || last_hs) busy_e[d] = 0;
        end
    endtask

    task automatic run_until_idle(input int rmode, input int budget);
        int n;
        n = 0;
        do begin
            tick(0, 0, rmode);
            n++;
        end while ((busy_e[0] || busy_e[1] || done_e[0] || done_e[1]) && n < budget);
        chk("run_timeout", 0, n < budget, 1);
    endtask

    initial begin
        int n;
        rst = 1; start = 0; abort = 0; m_ready = 0;
        model_clear();
        repeat (3) @(negedge clk);
        #1 chk_zero();
        @(negedge clk) rst = 0;

        // Full rate; a second start mid-run must not disturb the run length.
        full_rate = 1;
        tick(1, 0, 1);
        repeat (500) tick(0, 0, 1);
        tick(1, 0, 1);
        run_until_idle(1, 9000);

        // Random backpressure.
        full_rate = 0;
        tick(1, 0, 2);
        run_until_idle(2, 30000);

        // Long stall right after the first valid: reads must stop at the FIFO depth.
        tick(1, 0, 0);
        n = 0;
        while (!m_valid[0] && n < 20) begin tick(0, 0, 0); n++; end
        chk("first_valid_seen", 0, m_valid[0], 1);
        repeat (100) tick(0, 0, 0);
        chk("stall_issue", 0, issued[0], 2);
        chk("stall_issue", 1, issued[1], 3);
        run_until_idle(1, 9000);

        // Abort at element 1000, then restart from address 0.
        tick(1, 0, 1);
        n = 0;
        while (xfer[0] < 1000 && n < 2000) begin tick(0, 0, 1); n++; end
        chk("abort_point", 0, xfer[0], 1000);
        tick(0, 1, 1);
        repeat (10) tick(0, 0, 1);
        tick(1, 0, 1);
        repeat (20) tick(0, 0, 1);
        chk("restart_busy", 0, busy[0], 1);
        chk("restart_xfer", 0, xfer[0] > 10, 1);

        // Asynchronous reset between clock edges mid-run.
        @(negedge clk);
        #2 rst = 1;
        #1 chk_zero();
        model_clear();
        @(negedge clk);
        @(negedge clk) rst = 0;

        // Start together with abort is dropped; abort while idle does nothing.
        tick(1, 1, 1);
        tick(0, 0, 1);
        tick(0, 1, 1);
        tick(0, 0, 1);
        chk("start_abort_idle", 0, busy[0], 0);
        chk("start_abort_idle", 1, busy[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
